// File: rtl/vga_timing_gen_if.sv
// Video timing bus between the VGA timing generator and its colour source / display sink.
// The generator drives timing and colour; the sink supplies run request and per-pixel colour.
interface vga_timing_gen_if #(
  parameter int CW    = 11,
  parameter int RGB_W = 12
);
  logic             en;
  logic [RGB_W-1:0] rgb_in;
  logic             pix_en;
  logic [CW-1:0]    x;
  logic [CW-1:0]    y;
  logic             active;
  logic             line_start;
  logic             frame_start;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [RGB_W-1:0] rgb;
  logic [7:0]       frame_count;

  modport master (
    input  en, rgb_in,
    output pix_en, x, y, active, line_start, frame_start,
    output hsync, vsync, de, rgb, frame_count
  );

  modport slave (
    output en, rgb_in,
    input  pix_en, x, y, active, line_start, frame_start,
    input  hsync, vsync, de, rgb, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel-clock divider, H/V counters,
// one-pixel registered sync/colour stage, run/stop control and frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 11,
  parameter int RGB_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic             run_q;
  logic [DW-1:0]    div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [CW-1:0]    x_q, x_d;
  logic [CW-1:0]    y_q, y_d;
  logic [7:0]       fc_q, fc_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  logic             active_s0;
  logic             line_s0;
  logic             x_wrap;
  logic             y_wrap;

  assign x_wrap    = (x_q == H_LAST);
  assign y_wrap    = (y_q == V_LAST);
  assign active_s0 = run_q & (x_q < H_ACT) & (y_q < V_ACT);
  assign line_s0   = run_q & (x_q == '0);

  // Divider and strobe: pix_en is registered and dropped as soon as en falls.
  always_comb begin
    div_d    = div_q;
    pix_en_d = 1'b0;
    if (!run_q) begin
      div_d = '0;
    end else begin
      if (div_q == DIV_LAST) div_d = '0;
      else                   div_d = div_q + DW'(1);
      pix_en_d = bus.en & (div_q == DIV_LAST);
    end
  end

  // H/V counters and frame counter advance only on the pixel strobe.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fc_d = fc_q;
    if (!run_q) begin
      x_d = '0;
      y_d = '0;
    end else if (pix_en_q) begin
      if (x_wrap) begin
        x_d = '0;
        if (y_wrap) begin
          y_d  = '0;
          fc_d = fc_q + 8'd1;
        end else begin
          y_d = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // Stage-1 next values computed from the pixel currently on x/y.
  always_comb begin
    hs_d  = ((x_q >= HS_BEG) && (x_q < HS_END)) ? HS_ON : ~HS_ON;
    vs_d  = ((y_q >= VS_BEG) && (y_q < VS_END)) ? VS_ON : ~VS_ON;
    rgb_d = active_s0 ? bus.rgb_in : '0;
  end

  // Run flag, divider and pixel strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      run_q    <= bus.en;
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
    end
  end

  // Position counters and completed-frame count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
    end
  end

  // One-pixel output stage keeps syncs aligned with the registered colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else if (!run_q) begin
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else if (pix_en_q) begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= active_s0;
      rgb_q <= rgb_d;
    end
  end

  assign bus.pix_en      = pix_en_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.active      = active_s0;
  assign bus.line_start  = line_s0;
  assign bus.frame_start = line_s0 & (y_q == '0);
  assign bus.hsync       = run_q ? hs_q : ~HS_ON;
  assign bus.vsync       = run_q ? vs_q : ~VS_ON;
  assign bus.de          = run_q & de_q;
  assign bus.rgb         = run_q ? rgb_q : '0;
  assign bus.frame_count = fc_q;

endmodule
